// File: rtl/aip_pkg.sv
// Shared constants for the AIP responder: register-select codes, STATUS layout, start-FSM encoding.
package aip_pkg;

  localparam logic [4:0] CODE_MEMX   = 5'd0;
  localparam logic [4:0] CODE_PTRX   = 5'd1;
  localparam logic [4:0] CODE_MEMY   = 5'd2;
  localparam logic [4:0] CODE_PTRY   = 5'd3;
  localparam logic [4:0] CODE_MEMZ   = 5'd4;
  localparam logic [4:0] CODE_PTRZ   = 5'd5;
  localparam logic [4:0] CODE_CFG    = 5'd6;
  localparam logic [4:0] CODE_PTRCFG = 5'd7;
  localparam logic [4:0] CODE_STATUS = 5'd30;
  localparam logic [4:0] CODE_IPID   = 5'd31;

  localparam int unsigned FLAG_DONE = 0;
  localparam int unsigned FLAG_ERR  = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  function automatic logic code_mapped(input logic [4:0] code);
    return (code <= CODE_PTRCFG) || (code == CODE_STATUS) || (code == CODE_IPID);
  endfunction

endpackage

// File: rtl/aip_status_reg.sv
// Interrupt mask, sticky event flags (W1C, set wins over clear) and registered active-low int_req.
module aip_status_reg
  import aip_pkg::*;
(
  input  logic       clk,
  input  logic       rst_a,
  input  logic       wr_en,
  input  logic [7:0] wr_mask,
  input  logic [7:0] wr_clr,
  input  logic [7:0] set_flags,
  output logic [7:0] mask,
  output logic [7:0] flags,
  output logic       int_req
);

  logic [7:0] mask_nxt;
  logic [7:0] flags_nxt;

  always_comb begin
    mask_nxt  = wr_en ? wr_mask : mask;
    flags_nxt = (wr_en ? (flags & ~wr_clr) : flags) | set_flags;
  end

  // int_req tracks the flag/mask pair being loaded so it never lags the STATUS view
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      mask    <= '0;
      flags   <= '0;
      int_req <= 1'b1;
    end else begin
      mask    <= mask_nxt;
      flags   <= flags_nxt;
      int_req <= ~|(flags_nxt & mask_nxt);
    end
  end

endmodule

// File: rtl/aip_responder_if.sv
// AIP host-bus responder: register/pointer decode, core memory ports, start handshake.
// Optional AIP_ERR_FLAG_EN: flags[1] records dropped starts and unmapped accesses.
module aip_responder_if
  import aip_pkg::*;
#(
  parameter int unsigned   DW    = 32,
  parameter int unsigned   AW    = 4,
  parameter int unsigned   CFG_W = 10,
  parameter logic [DW-1:0] IP_ID = 32'h1000500A
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             en_s,
  input  logic [DW-1:0]    data_in,
  output logic [DW-1:0]    data_out,
  input  logic             write,
  input  logic             read,
  input  logic             start,
  input  logic [4:0]       conf_dbus,
  output logic             int_req,
  output logic             x_we,
  output logic             y_we,
  output logic [AW-1:0]    x_addr,
  output logic [AW-1:0]    y_addr,
  output logic [DW-1:0]    xy_wdata,
  output logic [AW-1:0]    z_addr,
  input  logic [DW-1:0]    z_rdata,
  output logic [CFG_W-1:0] cfg_size,
  output logic             core_start,
  input  logic             core_busy,
  input  logic             core_done
);

  logic          wr;
  logic          rd;
  logic          start_req;
  logic          start_acc;
  logic [AW-1:0] ptr_x;
  logic [AW-1:0] ptr_y;
  logic [AW-1:0] ptr_z;
  logic [1:0]    state;
  logic [7:0]    mask;
  logic [7:0]    flags;
  logic [7:0]    set_flags;
  logic [DW-1:0] rd_data;

  // a write in the same cycle as a read suppresses the read entirely
  assign wr        = en_s & write;
  assign rd        = en_s & read & ~write;
  assign start_req = en_s & start;
  assign start_acc = start_req && (state == ST_IDLE) && !core_busy;

  assign x_we       = wr && (conf_dbus == CODE_MEMX);
  assign y_we       = wr && (conf_dbus == CODE_MEMY);
  assign x_addr     = ptr_x;
  assign y_addr     = ptr_y;
  assign z_addr     = ptr_z;
  assign xy_wdata   = data_in;
  assign core_start = (state == ST_PULSE);

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      ptr_x    <= '0;
      ptr_y    <= '0;
      ptr_z    <= '0;
      cfg_size <= '0;
    end else if (wr) begin
      case (conf_dbus)
        CODE_MEMX: ptr_x    <= ptr_x + 1'b1;
        CODE_PTRX: ptr_x    <= data_in[AW-1:0];
        CODE_MEMY: ptr_y    <= ptr_y + 1'b1;
        CODE_PTRY: ptr_y    <= data_in[AW-1:0];
        CODE_PTRZ: ptr_z    <= data_in[AW-1:0];
        CODE_CFG:  cfg_size <= data_in[CFG_W-1:0];
        default: ;
      endcase
    end else if (rd && (conf_dbus == CODE_MEMZ)) begin
      ptr_z <= ptr_z + 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (conf_dbus)
      CODE_MEMZ:   rd_data = z_rdata;
      CODE_PTRX:   rd_data[AW-1:0] = ptr_x;
      CODE_PTRY:   rd_data[AW-1:0] = ptr_y;
      CODE_PTRZ:   rd_data[AW-1:0] = ptr_z;
      CODE_CFG:    rd_data[CFG_W-1:0] = cfg_size;
      CODE_STATUS: rd_data[31:0] = {8'd0, mask, 7'd0, core_busy, flags};
      CODE_IPID:   rd_data = IP_ID;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a)
      data_out <= '0;
    else if (rd)
      data_out <= rd_data;
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_acc) state <= ST_PULSE;
        ST_PULSE: state <= ST_WAIT;
        ST_WAIT:  if (core_done) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef AIP_ERR_FLAG_EN
  logic err_evt;
  assign err_evt   = (start_req & ~start_acc)
                   | (en_s & (write | read) & ~code_mapped(conf_dbus));
  assign set_flags = {6'd0, err_evt, core_done};
`else
  assign set_flags = {7'd0, core_done};
`endif

  aip_status_reg u_status (
    .clk       (clk),
    .rst_a     (rst_a),
    .wr_en     (wr && (conf_dbus == CODE_STATUS)),
    .wr_mask   (data_in[23:16]),
    .wr_clr    (data_in[7:0]),
    .set_flags (set_flags),
    .mask      (mask),
    .flags     (flags),
    .int_req   (int_req)
  );

endmodule
